// File: rtl/flash_write_responder_pkg.sv
// Shared MSX definitions: responder state encoding and the erased-flash fill byte.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// The ERASE state exists only when FLASH_ERASE_EN is defined.
package MSX;

`ifdef FLASH_ERASE_EN
  typedef enum logic [2:0] {IDLE, RD, WR, ERASE, DONE} flash_state_t;
`else
  typedef enum logic [2:0] {IDLE, RD, WR, DONE} flash_state_t;
`endif

  // Value held by every byte of a freshly erased flash block.
  localparam logic [7:0] ERASE_FILL = 8'hFF;

endpackage

// File: rtl/flash_erase_counter.sv
// Erase address generator: walks every byte offset of one aligned erase block.
// Latency: the address follows the offset register combinationally; offset steps one per advance.
// Backpressure: steps only on advance and saturates at the last offset instead of wrapping.
// Ports: clear (hold offset at 0), advance (one write acknowledged), block_base (upper
// address bits of the block), addr (current byte address), last (offset is the final one).
module flash_erase_counter #(
  parameter int ADDR_W     = 27,
  parameter int ERASE_BITS = 16
) (
  input  logic                     clk21m,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     advance,
  input  logic [ADDR_W-ERASE_BITS-1:0] block_base,
  output logic [ADDR_W-1:0]        addr,
  output logic                     last
);

  logic [ERASE_BITS-1:0] offset;

  assign last = &offset;
  assign addr = {block_base, offset};

  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) begin
      offset <= '0;
    end else if (clear) begin
      offset <= '0;
    end else if (advance && !last) begin
      // Saturate at the last offset so the walk never strays into the next block.
      offset <= offset + 1'b1;
    end
  end

endmodule

// File: rtl/flash_write_responder.sv
// Flash write emulation over a plain byte memory: byte program (NOR AND or overwrite) and block erase.
// Latency: program 4 cycles (overwrite) / 7 cycles (NOR read-modify-write) request to done with zero-wait memory.
// Backpressure: one request at a time; a request while busy (including the DONE cycle) is dropped and flagged on flash_overrun.
// Ports: flash_* is the request side (req/erase/addr/din in; ready/done/overrun out);
// mem_* is a req/ack memory port, request held with stable addr/din/rnw until ack.
// Config macro FLASH_ERASE_EN: defined = real block erase via flash_erase_counter;
// undefined = an erase request completes without touching memory.
module flash_write_responder
  import MSX::*;
#(
  parameter int ADDR_W      = 27,
  parameter int ERASE_BITS  = 16,
  parameter int PROGRAM_AND = 1
) (
  input  logic              clk21m,
  input  logic              reset_n,
  input  logic              flash_req,
  input  logic              flash_erase,
  input  logic [ADDR_W-1:0] flash_addr,
  input  logic [7:0]        flash_din,
  output logic              flash_ready,
  output logic              flash_done,
  output logic              flash_overrun,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_rnw,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [7:0]        mem_dout
);

  flash_state_t      state_q, state_d;
  logic [ADDR_W-1:0] lat_addr;
  logic [7:0]        lat_din;
  logic              lat_erase;
  logic [7:0]        old_q;
  logic [7:0]        wr_data;
  logic              acc;
  logic              launch;
  logic [ADDR_W-1:0] launch_addr;

  // An ack only counts while a request is outstanding; stray acks are ignored.
  assign acc         = mem_req & mem_ack;
  assign flash_ready = (state_q == IDLE);
  assign flash_done  = (state_q == DONE);
  assign wr_data     = lat_erase          ? ERASE_FILL :
                       (PROGRAM_AND != 0) ? (old_q & lat_din) : lat_din;

`ifdef FLASH_ERASE_EN
  logic [ADDR_W-1:0] erase_addr;
  logic              erase_last;

  flash_erase_counter #(
    .ADDR_W     (ADDR_W),
    .ERASE_BITS (ERASE_BITS)
  ) u_erase_counter (
    .clk21m     (clk21m),
    .reset_n    (reset_n),
    .clear      (state_q != ERASE),
    .advance    (acc && (state_q == ERASE)),
    .block_base (lat_addr[ADDR_W-1:ERASE_BITS]),
    .addr       (erase_addr),
    .last       (erase_last)
  );

  // A new access is launched only from a cycle with mem_req low, which also
  // guarantees the idle cycle between back-to-back accesses.
  assign launch      = !mem_req && (state_q inside {RD, WR, ERASE});
  assign launch_addr = (state_q == ERASE) ? erase_addr : lat_addr;
`else
  logic skip_q;

  // Erase without the erase engine passes through WR for two cycles with no
  // memory access, then completes.
  assign launch      = !mem_req && ((state_q == RD) || ((state_q == WR) && !lat_erase));
  assign launch_addr = lat_addr;

  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) skip_q <= 1'b0;
    else          skip_q <= (state_q == WR) && lat_erase;
  end
`endif

  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (flash_req) begin
          if (flash_erase) begin
`ifdef FLASH_ERASE_EN
            state_d = ERASE;
`else
            state_d = WR;
`endif
          end else if (PROGRAM_AND != 0) begin
            state_d = RD;
          end else begin
            state_d = WR;
          end
        end
      end
      RD:    if (acc) state_d = WR;
`ifdef FLASH_ERASE_EN
      WR:    if (acc) state_d = DONE;
      ERASE: if (acc && erase_last) state_d = DONE;
`else
      WR:    if (acc || skip_q) state_d = DONE;
`endif
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) begin
      lat_addr      <= '0;
      lat_din       <= '0;
      lat_erase     <= 1'b0;
      old_q         <= '0;
      flash_overrun <= 1'b0;
      mem_req       <= 1'b0;
      mem_rnw       <= 1'b1;
      mem_addr      <= '0;
      mem_din       <= '0;
    end else begin
      flash_overrun <= flash_req && !flash_ready;
      if (flash_req && flash_ready) begin
        lat_addr  <= flash_addr;
        lat_din   <= flash_din;
        lat_erase <= flash_erase;
      end
      if (acc) begin
        mem_req <= 1'b0;
        if (state_q == RD) old_q <= mem_dout;
      end else if (launch) begin
        mem_req  <= 1'b1;
        mem_addr <= launch_addr;
        mem_rnw  <= (state_q == RD);
        if (state_q != RD) mem_din <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_flash_write_responder.sv
// Directed bench: two responders (NOR AND and overwrite, 16-byte erase blocks)
// against zero-wait memory models that log every access.
module tb_flash_write_responder;

  logic        clk21m = 1'b0;
  logic        reset_n;
  logic [1:0]  f_req, f_erase, f_ready, f_done, f_ovr;
  logic [26:0] f_addr [2];
  logic [7:0]  f_din [2];
  logic [26:0] m_addr [2];
  logic [7:0]  m_din [2];
  logic [7:0]  m_dout [2] = '{8'h00, 8'h00};
  logic [1:0]  m_rnw, m_req, m_ack;
  logic [1:0]  m_ack_r = 2'b00;
  logic [1:0]  stray;
  logic [7:0]  rd_val [2];

  int errors = 0;
  int checks = 0;
  int wr_cnt [2]    = '{0, 0};
  int rd_cnt [2]    = '{0, 0};
  int done_cnt [2]  = '{0, 0};
  int rise_cnt [2]  = '{0, 0};
  int proto_bad [2] = '{0, 0};
  logic [26:0] log_addr [2][64];
  logic [7:0]  log_dat [2][64];
  logic [1:0]  p_req = 2'b00, p_ack = 2'b00, p_rnw = 2'b00;
  logic [26:0] p_addr [2] = '{27'h0, 27'h0};
  logic [7:0]  p_din [2]  = '{8'h00, 8'h00};

  always #5 clk21m = ~clk21m;
  assign m_ack = m_ack_r | stray;

  flash_write_responder #(.ADDR_W(27), .ERASE_BITS(4), .PROGRAM_AND(1)) u_and (
    .clk21m(clk21m), .reset_n(reset_n),
    .flash_req(f_req[0]), .flash_erase(f_erase[0]), .flash_addr(f_addr[0]), .flash_din(f_din[0]),
    .flash_ready(f_ready[0]), .flash_done(f_done[0]), .flash_overrun(f_ovr[0]),
    .mem_addr(m_addr[0]), .mem_din(m_din[0]), .mem_rnw(m_rnw[0]), .mem_req(m_req[0]),
    .mem_ack(m_ack[0]), .mem_dout(m_dout[0]));

  flash_write_responder #(.ADDR_W(27), .ERASE_BITS(4), .PROGRAM_AND(0)) u_ovw (
    .clk21m(clk21m), .reset_n(reset_n),
    .flash_req(f_req[1]), .flash_erase(f_erase[1]), .flash_addr(f_addr[1]), .flash_din(f_din[1]),
    .flash_ready(f_ready[1]), .flash_done(f_done[1]), .flash_overrun(f_ovr[1]),
    .mem_addr(m_addr[1]), .mem_din(m_din[1]), .mem_rnw(m_rnw[1]), .mem_req(m_req[1]),
    .mem_ack(m_ack[1]), .mem_dout(m_dout[1]));

  // Zero-wait memories (ack the cycle after the request is seen) plus protocol monitors.
  always @(posedge clk21m) begin
    for (int g = 0; g < 2; g++) begin
      m_ack_r[g] <= 1'b0;
      if (m_req[g] && !m_ack_r[g]) begin
        m_ack_r[g] <= 1'b1;
        m_dout[g]  <= rd_val[g];
        if (m_rnw[g]) begin
          rd_cnt[g] <= rd_cnt[g] + 1;
        end else begin
          log_addr[g][wr_cnt[g] % 64] <= m_addr[g];
          log_dat[g][wr_cnt[g] % 64]  <= m_din[g];
          wr_cnt[g] <= wr_cnt[g] + 1;
        end
      end
      if (f_done[g]) done_cnt[g] <= done_cnt[g] + 1;
      if (m_req[g] && !p_req[g]) rise_cnt[g] <= rise_cnt[g] + 1;
      if (reset_n) begin
        if (p_req[g] && !p_ack[g] && (!m_req[g] || m_addr[g] != p_addr[g] ||
            m_din[g] != p_din[g] || m_rnw[g] != p_rnw[g]))
          proto_bad[g] <= proto_bad[g] + 1;
        if (p_req[g] && p_ack[g] && m_req[g])
          proto_bad[g] <= proto_bad[g] + 1;
      end
      p_req[g]  <= m_req[g];
      p_ack[g]  <= m_ack[g];
      p_rnw[g]  <= m_rnw[g];
      p_addr[g] <= m_addr[g];
      p_din[g]  <= m_din[g];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_ready"}, 32'(f_ready[d]), 32'd1);
      chk({tag, "_done"},  32'(f_done[d]),  32'd0);
      chk({tag, "_ovr"},   32'(f_ovr[d]),   32'd0);
      chk({tag, "_req"},   32'(m_req[d]),   32'd0);
      chk({tag, "_rnw"},   32'(m_rnw[d]),   32'd1);
      chk({tag, "_addr"},  32'(m_addr[d]),  32'd0);
      chk({tag, "_din"},   32'(m_din[d]),   32'd0);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) begin @(posedge clk21m); #1; end
  endtask

  // Drives a one-cycle request; returns one cycle after it (cycle 1).
  task automatic req_go(input int d, input logic er, input logic [26:0] a, input logic [7:0] din);
    @(posedge clk21m); #1;
    f_req[d] = 1'b1; f_erase[d] = er; f_addr[d] = a; f_din[d] = din;
    @(posedge clk21m); #1;
    f_req[d] = 1'b0;
  endtask

  // Returns the cycle number (request cycle = 0) in which flash_done is seen, or -1.
  task automatic wait_done(input int d, input int start, input int limit, output int n);
    n = start;
    while (!f_done[d] && n < limit) begin @(posedge clk21m); #1; n++; end
    if (!f_done[d]) n = -1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, w0, r0, d0, s0, w1, r1, d1, s1;
    reset_n = 1'b1; f_req = '0; f_erase = '0; stray = '0;
    f_addr = '{27'h0, 27'h0}; f_din = '{8'h00, 8'h00}; rd_val = '{8'h00, 8'h00};
    #3 reset_n = 1'b0;
    #1 chk_reset("rst_init");
    tick(2);
    reset_n = 1'b1;
    tick(1);

    // NOR program: old F0 AND din 3C -> 30, done at cycle 7.
    rd_val[0] = 8'hF0; w0 = wr_cnt[0]; r0 = rd_cnt[0];
    req_go(0, 1'b0, 27'h10, 8'h3C);
    chk("and_ready_drop", 32'(f_ready[0]), 32'd0);
    wait_done(0, 1, 40, n);
    chk("and_latency", n, 7);
    tick(1);
    chk("and_ready_back", 32'(f_ready[0]), 32'd1);
    chk("and_done_1cyc", 32'(f_done[0]), 32'd0);
    chk("and_reads", rd_cnt[0] - r0, 1);
    chk("and_writes", wr_cnt[0] - w0, 1);
    chk("and_waddr", 32'(log_addr[0][w0 % 64]), 32'h10);
    chk("and_wdata", 32'(log_dat[0][w0 % 64]), 32'h30);

    // NOR program at the top address: old AA AND din 0F -> 0A.
    rd_val[0] = 8'hAA; w0 = wr_cnt[0];
    req_go(0, 1'b0, 27'h7FFFFFF, 8'h0F);
    wait_done(0, 1, 40, n);
    chk("top_latency", n, 7);
    tick(1);
    chk("top_waddr", 32'(log_addr[0][w0 % 64]), 32'h7FFFFFF);
    chk("top_wdata", 32'(log_dat[0][w0 % 64]), 32'h0A);

    // Overwrite program: din A5 written as-is, no read, done at cycle 4.
    rd_val[1] = 8'h0F; w1 = wr_cnt[1]; r1 = rd_cnt[1];
    req_go(1, 1'b0, 27'h55, 8'hA5);
    wait_done(1, 1, 40, n);
    chk("ovw_latency", n, 4);
    tick(1);
    chk("ovw_reads", rd_cnt[1] - r1, 0);
    chk("ovw_writes", wr_cnt[1] - w1, 1);
    chk("ovw_waddr", 32'(log_addr[1][w1 % 64]), 32'h55);
    chk("ovw_wdata", 32'(log_dat[1][w1 % 64]), 32'hA5);

    // Second request while busy: dropped with an overrun pulse; first completes intact.
    rd_val[0] = 8'h3F; w0 = wr_cnt[0]; d0 = done_cnt[0];
    req_go(0, 1'b0, 27'h20, 8'hC3);
    tick(1);
    f_req[0] = 1'b1; f_erase[0] = 1'b1; f_addr[0] = 27'h99; f_din[0] = 8'h00;
    tick(1);
    f_req[0] = 1'b0;
    chk("busy_ovr_pulse", 32'(f_ovr[0]), 32'd1);
    tick(1);
    chk("busy_ovr_clear", 32'(f_ovr[0]), 32'd0);
    wait_done(0, 4, 40, n);
    chk("busy_latency", n, 7);
    tick(3);
    chk("busy_done_cnt", done_cnt[0] - d0, 1);
    chk("busy_writes", wr_cnt[0] - w0, 1);
    chk("busy_waddr", 32'(log_addr[0][w0 % 64]), 32'h20);
    chk("busy_wdata", 32'(log_dat[0][w0 % 64]), 32'h03);

    // Request in the DONE cycle counts as busy.
    w1 = wr_cnt[1];
    req_go(1, 1'b0, 27'h66, 8'h11);
    wait_done(1, 1, 40, n);
    chk("donereq_latency", n, 4);
    f_req[1] = 1'b1; f_erase[1] = 1'b0; f_addr[1] = 27'h77; f_din[1] = 8'h22;
    tick(1);
    f_req[1] = 1'b0;
    chk("donereq_ovr", 32'(f_ovr[1]), 32'd1);
    chk("donereq_ready", 32'(f_ready[1]), 32'd1);
    tick(4);
    chk("donereq_writes", wr_cnt[1] - w1, 1);

    // Stray ack with no request outstanding is ignored.
    w1 = wr_cnt[1]; d1 = done_cnt[1]; s1 = rise_cnt[1];
    stray[1] = 1'b1;
    tick(1);
    stray[1] = 1'b0;
    tick(3);
    chk("stray_writes", wr_cnt[1] - w1, 0);
    chk("stray_done", done_cnt[1] - d1, 0);
    chk("stray_req", rise_cnt[1] - s1, 0);

`ifdef FLASH_ERASE_EN
    // Block erase of the 16-byte block holding 1237.
    w0 = wr_cnt[0]; r0 = rd_cnt[0]; d0 = done_cnt[0];
    req_go(0, 1'b1, 27'h1237, 8'h00);
    wait_done(0, 1, 200, n);
    chk("erase_done_seen", 32'(f_done[0]), 32'd1);
    tick(3);
    chk("erase_writes", wr_cnt[0] - w0, 16);
    chk("erase_reads", rd_cnt[0] - r0, 0);
    chk("erase_done_cnt", done_cnt[0] - d0, 1);
    for (int i = 0; i < 16; i++) begin
      chk("erase_addr", 32'(log_addr[0][(w0 + i) % 64]), 32'h1230 + 32'(i));
      chk("erase_data", 32'(log_dat[0][(w0 + i) % 64]), 32'hFF);
    end

    // Reset at erase offset 5.
    req_go(0, 1'b1, 27'h4321, 8'h00);
    n = 0;
    while (!(m_req[0] && m_addr[0] == 27'h4325) && n < 100) begin tick(1); n++; end
    chk("erase_off5", 32'(m_addr[0]), 32'h4325);
    reset_n = 1'b0;
    #1 chk_reset("rst_mid");
`else
    // Erase without the erase engine: done at cycle 3, memory untouched.
    w0 = wr_cnt[0]; r0 = rd_cnt[0]; d0 = done_cnt[0]; s0 = rise_cnt[0];
    req_go(0, 1'b1, 27'h1237, 8'h00);
    wait_done(0, 1, 20, n);
    chk("noerase_latency", n, 3);
    tick(2);
    chk("noerase_req", rise_cnt[0] - s0, 0);
    chk("noerase_writes", wr_cnt[0] - w0, 0);
    chk("noerase_reads", rd_cnt[0] - r0, 0);
    chk("noerase_done_cnt", done_cnt[0] - d0, 1);

    // Reset during the read of a NOR program.
    rd_val[0] = 8'h77;
    req_go(0, 1'b0, 27'h300, 8'h01);
    n = 0;
    while (!m_req[0] && n < 20) begin tick(1); n++; end
    chk("mid_rd_addr", 32'(m_addr[0]), 32'h300);
    chk("mid_rd_rnw", 32'(m_rnw[0]), 32'd1);
    reset_n = 1'b0;
    #1 chk_reset("rst_mid");
`endif
    tick(2);
    reset_n = 1'b1;
    w0 = wr_cnt[0]; r0 = rd_cnt[0]; d0 = done_cnt[0]; s0 = rise_cnt[0];
    tick(1);
    stray[0] = 1'b1;
    tick(1);
    stray[0] = 1'b0;
    tick(4);
    chk("post_rst_req", rise_cnt[0] - s0, 0);
    chk("post_rst_access", (wr_cnt[0] - w0) + (rd_cnt[0] - r0), 0);
    chk("post_rst_done", done_cnt[0] - d0, 0);
    chk("post_rst_ready", 32'(f_ready[0]), 32'd1);

    // The responder is usable again after the abort.
    rd_val[0] = 8'hC0; w0 = wr_cnt[0];
    req_go(0, 1'b0, 27'h400, 8'h5F);
    wait_done(0, 1, 40, n);
    chk("recover_latency", n, 7);
    tick(1);
    chk("recover_wdata", 32'(log_dat[0][w0 % 64]), 32'h40);

    chk("proto_and", proto_bad[0], 0);
    chk("proto_ovw", proto_bad[1], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flash_write_responder.md
FLASH_WRITE_RESPONDER -- requirements
Module: flash_write_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 27: flash/memory address width.
REQ-002 SHALL have parameter ERASE_BITS, default 16: log2 of the erase-block size in bytes.
REQ-003 SHALL have parameter PROGRAM_AND, default 1: 1 selects NOR semantics (new = old AND din); 0 selects a plain overwrite.
REQ-004 SHALL have the port list below; one clock, and reset is asynchronous and active-low:
 clk21m  in  1  system clock
 reset_n  in  1  asynchronous active-low reset
 flash_req  in  1  one-cycle request strobe
 flash_erase  in  1  qualifies flash_req: 1 = block erase, 0 = byte program
 flash_addr  in  ADDR_W  target address
 flash_din  in  8  program data
 flash_ready  out  1  idle; able to accept a request
 flash_done  out  1  one-cycle completion pulse
 flash_overrun  out  1  one-cycle pulse when a request is dropped
 mem_addr  out  ADDR_W  memory address
 mem_din  out  8  memory write data
 mem_rnw  out  1  1 = read, 0 = write
 mem_req  out  1  access request, held until acknowledged
 mem_ack  in  1  one-cycle access-complete pulse
 mem_dout  in  8  read data, valid in the mem_ack cycle

Function
REQ-005 SHALL use the states IDLE, RD, WR, ERASE, DONE.
REQ-006 In IDLE with flash_req=1, SHALL latch flash_addr, flash_din and flash_erase, and drop flash_ready on the next cycle.
REQ-007 When the latched request is a program and PROGRAM_AND=1, SHALL go IDLE->RD, issue a read at the latched address, capture mem_dout on mem_ack, then go to WR.
REQ-008 When the latched request is a program and PROGRAM_AND=0, SHALL go IDLE->WR directly.
REQ-009 WR SHALL write (old AND din) or din, as selected by REQ-003, then go to DONE on mem_ack.
REQ-010 ERASE SHALL write 8'hFF to every address of the aligned block: base = addr with its low ERASE_BITS bits cleared; offset counter runs 0 .. 2^ERASE_BITS-1.
REQ-011 ERASE SHALL advance the offset counter on each mem_ack and go to DONE on the ack for the last offset; the counter SHALL not wrap into the next block.
REQ-012 mem_req SHALL be held high with stable addr, din and rnw until mem_ack.
REQ-013 mem_req SHALL be low for at least one cycle between consecutive accesses.
REQ-014 A mem_ack arriving while mem_req=0 SHALL be ignored.
REQ-015 DONE SHALL last one cycle: flash_done=1, then go to IDLE with flash_ready=1 on the following cycle.
REQ-016 A flash_req while flash_ready=0 SHALL be dropped and SHALL pulse flash_overrun for one cycle; state and latched data are unchanged.
REQ-017 flash_req coincident with the DONE cycle SHALL count as busy and be handled per REQ-016.
REQ-018 Minimum program latency, request to flash_done with a zero-wait memory: 4 cycles with PROGRAM_AND=0, 7 cycles with PROGRAM_AND=1.

Reset
REQ-019 Assertion of reset_n SHALL act immediately, including mid-access or mid-erase: state=IDLE, flash_ready=1, flash_done=0, flash_overrun=0, mem_req=0, mem_rnw=1, mem_addr=0, mem_din=0, erase counter=0.
REQ-020 After reset release, an outstanding mem_ack from an aborted access SHALL be ignored per REQ-014.

Configuration
REQ-021 With macro FLASH_ERASE_EN defined, SHALL implement ERASE as specified in REQ-010 and REQ-011.
REQ-022 Without FLASH_ERASE_EN, SHALL omit the ERASE state and counter, and SHALL complete an erase request as an immediate DONE with no memory access.

Structure
REQ-023 The state enum and the 8'hFF erase-fill constant SHALL reside in the shared package MSX.
REQ-024 The erase address generator SHALL be a sub-module named flash_erase_counter, instantiated only under FLASH_ERASE_EN.

Verification
REQ-025 Program, PROGRAM_AND=1: old=8'hF0, din=8'h3C at addr 27'h10 -> write of 8'h30 to 27'h10, flash_done 7 cycles after the request with zero-wait ack.
REQ-026 Program, PROGRAM_AND=0: din=8'hA5 -> single write of 8'hA5, no read issued, flash_done 4 cycles after the request.
REQ-027 Erase, ERASE_BITS=4, addr 27'h1237 -> 16 writes of 8'hFF to 27'h1230..27'h123F, then one flash_done.
REQ-028 Second flash_req issued while the first is busy -> flash_overrun pulse, first request completes unchanged, exactly one flash_done.
REQ-029 reset_n asserted at erase offset 5 -> all outputs take reset values immediately; a stray mem_ack after release produces no access and no flash_done.
REQ-030 FLASH_ERASE_EN undefined, erase request -> flash_done 3 cycles after the request, mem_req never asserted.
